// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that merges nports val/rdy request streams into one
// downstream val/rdy stream. The winning message is held in a one-entry
// output register and tagged with its source port index. The register can
// refill in the same cycle it drains, so it sustains one message per cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// empty  | r_full=0: output register free, any valid requester may win
// full   | r_full=1: r_buf_msg/r_buf_src presented downstream until taken
module stream_rr_arbiter #(
  parameter int nports = 2,
  parameter int nbits  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [nbits-1:0]           istream_msg [nports],
  input  logic                       istream_val [nports],
  output logic                       istream_rdy [nports],
  output logic [nbits-1:0]           ostream_msg,
  output logic [$clog2(nports)-1:0]  ostream_src,
  output logic                       ostream_val,
  input  logic                       ostream_rdy
);

  localparam int SW = $clog2(nports);

  logic             r_full;
  logic [nbits-1:0] r_buf_msg;
  logic [SW-1:0]    r_buf_src;
  logic [SW-1:0]    r_ptr;

  logic             w_can_accept;
  logic             w_grant_any;
  logic [SW-1:0]    w_grant_idx;
  logic             w_grant;
  logic [SW-1:0]    w_ptr_next;

  // The register can take a new entry if it is empty or is being drained now.
  assign w_can_accept = !r_full || ostream_rdy;
  assign w_grant      = !reset && w_can_accept && w_grant_any;

  // Rotating priority search starting at r_ptr. Walking from the far end back
  // towards r_ptr lets the nearest valid port overwrite the earlier picks.
  always_comb begin
    int            j;
    logic [SW-1:0] cand;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    j           = 0;
    cand        = '0;
    for (int i = nports - 1; i >= 0; i--) begin
      j = int'(r_ptr) + i;
      if (j >= nports) j = j - nports;
      cand = SW'(j);
      if (istream_val[cand]) begin
        w_grant_any = 1'b1;
        w_grant_idx = cand;
      end
    end
  end

  // One-hot ready back to the winner only; reset forces every ready low.
  always_comb begin
    for (int k = 0; k < nports; k++) begin
      istream_rdy[k] = w_grant && (w_grant_idx == SW'(k));
    end
  end

  // Pointer wraps explicitly so it never reaches nports when nports is not 2^n.
  assign w_ptr_next = (w_grant_idx == SW'(nports - 1)) ? '0 : w_grant_idx + 1'b1;

  // Output register and priority pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full    <= 1'b0;
      r_buf_msg <= '0;
      r_buf_src <= '0;
      r_ptr     <= '0;
    end else if (w_grant) begin
      r_full    <= 1'b1;
      r_buf_msg <= istream_msg[w_grant_idx];
      r_buf_src <= w_grant_idx;
      r_ptr     <= w_ptr_next;
    end else if (r_full && ostream_rdy) begin
      r_full    <= 1'b0;
    end
  end

  assign ostream_val = r_full;
  assign ostream_msg = r_buf_msg;
  assign ostream_src = r_buf_src;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: a 4-port and a 3-port instance run side by
// side against a reference model that picks the valid port nearest the
// priority pointer by rotational distance.
module tb_stream_rr_arbiter;

  localparam int NB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Stimulus for both instances; instance 1 uses only ports 0..2.
  logic          tv [2][4];
  logic [NB-1:0] tm [2][4];
  logic          tr [2];

  logic [NB-1:0] msg_a [4];
  logic          val_a [4];
  logic          rdy_a [4];
  logic [NB-1:0] omsg_a;
  logic [1:0]    osrc_a;
  logic          oval_a;

  logic [NB-1:0] msg_b [3];
  logic          val_b [3];
  logic          rdy_b [3];
  logic [NB-1:0] omsg_b;
  logic [1:0]    osrc_b;
  logic          oval_b;

  // Fan the stimulus arrays out to the two instances.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      val_a[i] = tv[0][i];
      msg_a[i] = tm[0][i];
    end
    for (int i = 0; i < 3; i++) begin
      val_b[i] = tv[1][i];
      msg_b[i] = tm[1][i];
    end
  end

  stream_rr_arbiter #(.nports(4), .nbits(NB)) u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .istream_msg (msg_a),
    .istream_val (val_a),
    .istream_rdy (rdy_a),
    .ostream_msg (omsg_a),
    .ostream_src (osrc_a),
    .ostream_val (oval_a),
    .ostream_rdy (tr[0])
  );

  stream_rr_arbiter #(.nports(3), .nbits(NB)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .istream_msg (msg_b),
    .istream_val (val_b),
    .istream_rdy (rdy_b),
    .ostream_msg (omsg_b),
    .ostream_src (osrc_b),
    .ostream_val (oval_b),
    .ostream_rdy (tr[1])
  );

  // Reference model state.
  int          np [2] = '{4, 3};
  int          m_full [2];
  int          m_ptr [2];
  int          m_src [2];
  logic [NB-1:0] m_msg [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner = valid port with the smallest rotational distance from ptr.
  function automatic int pick(input int k);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = 99;
    if (reset) return -1;
    if (m_full[k] != 0 && !tr[k]) return -1;
    for (int p = 0; p < np[k]; p++) begin
      if (tv[k][p]) begin
        d = (p - m_ptr[k] + np[k]) % np[k];
        if (d < bd) begin
          bd   = d;
          best = p;
        end
      end
    end
    return best;
  endfunction

  // Called just after a falling edge with inputs applied: check the
  // combinational grant and the registered outputs, advance one clock,
  // update the model and return at the next falling edge.
  task automatic cycle();
    int         g [2];
    logic [3:0] er;
    logic [3:0] ar;
    #1;
    for (int k = 0; k < 2; k++) begin
      g[k] = pick(k);
      er = '0;
      if (g[k] >= 0) er[g[k]] = 1'b1;
      ar = '0;
      for (int p = 0; p < np[k]; p++) ar[p] = (k == 0) ? rdy_a[p] : rdy_b[p];
      chk((k == 0) ? "rdy_a" : "rdy_b", 64'(ar), 64'(er));
      chk((k == 0) ? "val_a" : "val_b", 64'((k == 0) ? oval_a : oval_b), 64'(m_full[k] != 0));
      chk((k == 0) ? "msg_a" : "msg_b", 64'((k == 0) ? omsg_a : omsg_b), 64'(m_msg[k]));
      chk((k == 0) ? "src_a" : "src_b", 64'((k == 0) ? osrc_a : osrc_b), 64'(m_src[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_full[k] = 0; m_msg[k] = '0; m_src[k] = 0; m_ptr[k] = 0;
      end else if (g[k] >= 0) begin
        m_full[k] = 1;
        m_msg[k]  = tm[k][g[k]];
        m_src[k]  = g[k];
        m_ptr[k]  = (g[k] + 1) % np[k];
      end else if (m_full[k] != 0 && tr[k]) begin
        m_full[k] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_vals(input int k, input logic [3:0] v, input logic r);
    for (int p = 0; p < 4; p++) begin
      tv[k][p] = v[p];
      tm[k][p] = 32'h100 + 32'(p) + 32'(k * 16);
    end
    tr[k] = r;
  endtask

  initial begin
    reset = 1'b1;
    set_vals(0, 4'hF, 1'b1);
    set_vals(1, 4'h7, 1'b1);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0; m_msg[k] = '0; m_src[k] = 0; m_ptr[k] = 0;
    end

    // Reset held two cycles with everything valid and ready.
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("first_grant_p0", 64'(rdy_a[0]), 64'd1);
    cycle();
    set_vals(0, 4'h0, 1'b1);
    set_vals(1, 4'h0, 1'b1);
    cycle();

    // Single requester on port 2.
    set_vals(0, 4'b0100, 1'b1);
    tm[0][2] = 32'hA5A5_0002;
    #1;
    chk("single_rdy2", 64'(rdy_a[2]), 64'd1);
    cycle();
    set_vals(0, 4'h0, 1'b1);
    chk("single_msg", 64'(omsg_a), 64'hA5A5_0002);
    chk("single_src", 64'(osrc_a), 64'd2);
    cycle();

    // Full contention: one message per cycle in rotating order.
    set_vals(0, 4'hF, 1'b1);
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("contend_val", 64'(oval_a), 64'd1);
      chk("contend_src", 64'(osrc_a), 64'((3 + c) % 4));
    end
    set_vals(0, 4'h0, 1'b1);
    cycle();

    // Backpressure: hold src=1/0x11, then release to get 3 then 0.
    set_vals(0, 4'b0010, 1'b1);
    tm[0][1] = 32'h11;
    cycle();
    set_vals(0, 4'b1001, 1'b0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_msg", 64'(omsg_a), 64'h11);
      chk("bp_src", 64'(osrc_a), 64'd1);
    end
    tr[0] = 1'b1;
    cycle();
    chk("bp_rel_first", 64'(osrc_a), 64'd3);
    cycle();
    chk("bp_rel_second", 64'(osrc_a), 64'd0);
    set_vals(0, 4'h0, 1'b1);
    cycle();

    // Skip and wrap on the 3-port instance.
    set_vals(1, 4'b010, 1'b1);
    cycle();
    set_vals(1, 4'b001, 1'b1);
    cycle();
    chk("wrap_src0", 64'(osrc_b), 64'd0);
    set_vals(1, 4'b101, 1'b1);
    cycle();
    chk("wrap_src2", 64'(osrc_b), 64'd2);
    set_vals(1, 4'b000, 1'b1);
    cycle();

    // Reset mid-stream discards the buffered entry.
    set_vals(0, 4'b0100, 1'b1);
    cycle();
    set_vals(0, 4'h0, 1'b0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_mid_val", 64'(oval_a), 64'd0);
    set_vals(0, 4'hF, 1'b1);
    #1;
    chk("rst_mid_p0", 64'(rdy_a[0]), 64'd1);
    cycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < 4; p++) begin
          tv[k][p] = ($urandom_range(0, 99) < 55);
          tm[k][p] = $urandom;
        end
        tr[k] = ($urandom_range(0, 99) < 65);
      end
      reset = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
